// File: rtl/swd_pkg.sv
// swd_pkg: ack codes, field widths and controller states shared by the SWD transfer sequencer.
package swd_pkg;
    localparam int ACK_W  = 3;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;
    localparam logic [ACK_W-1:0] ACK_OK     = 3'b001;
    localparam logic [ACK_W-1:0] ACK_WAIT   = 3'b010;
    localparam logic [ACK_W-1:0] ACK_FAULT  = 3'b100;
    localparam logic [ACK_W-1:0] ACK_NORESP = 3'b111;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_BUSY   = 3'd2,
        ST_EVAL   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;
endpackage

// File: rtl/swd_xfer_ctl.sv
// swd_xfer_ctl: launches one SWD transfer into the bit engine, re-issues on WAIT, returns one response.
// Optional launch watchdog enabled by defining SWDCTL_TIMEOUT_EN.
module swd_xfer_ctl
    import swd_pkg::*;
#(
    parameter int RETRY_W        = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_apndp,
    input  logic               req_rnw,
    input  logic [ADDR_W-1:0]  req_addr32,
    input  logic [DATA_W-1:0]  req_wdata,
    input  logic [RETRY_W-1:0] wait_retry,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ACK_W-1:0]   rsp_ack,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_perr,
    output logic [RETRY_W-1:0] rsp_retries,
    output logic               rsp_timeout,
    output logic               go,
    output logic               if_apndp,
    output logic               if_rnw,
    output logic [ADDR_W-1:0]  if_addr32,
    output logic [DATA_W-1:0]  if_dwrite,
    input  logic [ACK_W-1:0]   if_ack,
    input  logic [DATA_W-1:0]  if_dread,
    input  logic               if_perr,
    input  logic               if_idle
);
    state_e              state_q, state_d;
    logic                apndp_q, apndp_d, rnw_q, rnw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dwrite_q, dwrite_d, rdata_q, rdata_d;
    logic [RETRY_W-1:0]  remain_q, remain_d, retries_q, retries_d;
    logic [ACK_W-1:0]    ack_q, ack_d;
    logic                perr_q, perr_d;
`ifdef SWDCTL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                timeout_q, timeout_d;
`endif

    assign req_ready   = rst && state_q == ST_IDLE && if_idle;
    assign rsp_valid   = state_q == ST_RESP;
    assign go          = state_q == ST_LAUNCH;
    assign if_apndp    = apndp_q;
    assign if_rnw      = rnw_q;
    assign if_addr32   = addr_q;
    assign if_dwrite   = dwrite_q;
    assign rsp_ack     = ack_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_perr    = perr_q;
    assign rsp_retries = retries_q;
`ifdef SWDCTL_TIMEOUT_EN
    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        apndp_d   = apndp_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        dwrite_d  = dwrite_q;
        remain_d  = remain_q;
        retries_d = retries_q;
        ack_d     = ack_q;
        rdata_d   = rdata_q;
        perr_d    = perr_q;
`ifdef SWDCTL_TIMEOUT_EN
        tmo_d     = tmo_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE: if (req_valid && req_ready) begin
                apndp_d   = req_apndp;
                rnw_d     = req_rnw;
                addr_d    = req_addr32;
                dwrite_d  = req_wdata;
                remain_d  = wait_retry;
                retries_d = '0;
                state_d   = ST_LAUNCH;
`ifdef SWDCTL_TIMEOUT_EN
                tmo_d     = TW'(TIMEOUT_CYCLES);
                timeout_d = 1'b0;
`endif
            end
            ST_LAUNCH: state_d = if_idle ? ST_LAUNCH : ST_BUSY;
            ST_BUSY:   state_d = if_idle ? ST_EVAL : ST_BUSY;
            ST_EVAL: if (if_ack == ACK_WAIT && remain_q != '0) begin
                remain_d  = remain_q - RETRY_W'(1);
                retries_d = retries_q + RETRY_W'(1);
                state_d   = ST_LAUNCH;
`ifdef SWDCTL_TIMEOUT_EN
                tmo_d     = TW'(TIMEOUT_CYCLES);
`endif
            end else begin
                ack_d   = if_ack;
                rdata_d = rnw_q ? if_dread : '0;
                perr_d  = if_perr & rnw_q;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = rsp_ready ? ST_IDLE : ST_RESP;
            default: state_d = ST_IDLE;
        endcase
`ifdef SWDCTL_TIMEOUT_EN
        // Watchdog expiry overrides whatever the engine handshake would have done this cycle.
        if (state_q == ST_LAUNCH || state_q == ST_BUSY) begin
            tmo_d = tmo_q - TW'(1);
            if (tmo_q <= TW'(1)) begin
                timeout_d = 1'b1;
                ack_d     = '0;
                rdata_d   = '0;
                perr_d    = 1'b0;
                state_d   = ST_RESP;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            apndp_q   <= 1'b0;
            rnw_q     <= 1'b0;
            addr_q    <= '0;
            dwrite_q  <= '0;
            remain_q  <= '0;
            retries_q <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            perr_q    <= 1'b0;
`ifdef SWDCTL_TIMEOUT_EN
            tmo_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            apndp_q   <= apndp_d;
            rnw_q     <= rnw_d;
            addr_q    <= addr_d;
            dwrite_q  <= dwrite_d;
            remain_q  <= remain_d;
            retries_q <= retries_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            perr_q    <= perr_d;
`ifdef SWDCTL_TIMEOUT_EN
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
`endif
        end
    end
endmodule
